// File: rtl/led_pkg.sv
// Shared definitions for the LED event blinker: state encoding, board-scale
// and sim-scale timing constants, and a width helper.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int BOARD_ON_CYCLES   = 50_000_000;
  localparam int BOARD_OFF_CYCLES  = 25_000_000;
  localparam int BOARD_MAX_PENDING = 15;

  localparam int SIM_ON_CYCLES     = 4;
  localparam int SIM_OFF_CYCLES    = 2;
  localparam int SIM_MAX_PENDING   = 3;

  // $clog2 of 1 is 0; keep every counter at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Restartable interval timer: counts 0..limit-1 after start and pulses done
// for the single cycle in which the terminal count is held.
module interval_timer #(
  parameter int CW = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [CW:0] limit,
  output logic        done
);

  localparam logic [CW:0] ONE = (CW+1)'(1);

  logic [CW-1:0] count;
  logic          run;

  // limit is one bit wider than count so a power-of-two period still fits.
  assign done = run && ({1'b0, count} == (limit - ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= 1'b0;
      count <= '0;
    end else if (start) begin
      run   <= 1'b1;
      count <= '0;
    end else if (done) begin
      run   <= 1'b0;
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/led_event_blinker.sv
// Turns one-cycle event pulses into fixed-length LED blinks, queuing events
// that arrive mid-blink in a saturating pending counter with sticky overflow.
module led_event_blinker
  import led_pkg::*;
#(
  parameter int  ON_CYCLES   = BOARD_ON_CYCLES,
  parameter int  OFF_CYCLES  = BOARD_OFF_CYCLES,
  parameter int  MAX_PENDING = BOARD_MAX_PENDING,
  localparam int PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          event_in,
  input  logic          clear_ovf,
  output logic          led_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int CW = cnt_width((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);
  localparam logic [CW:0]   ON_LIM  = (CW+1)'(ON_CYCLES);
  localparam logic [CW:0]   OFF_LIM = (CW+1)'(OFF_CYCLES);
  localparam logic [PW-1:0] PMAX    = PW'(MAX_PENDING);

  state_t      state, state_nxt;
  logic        start, deq, accept, drop, done;
  logic [CW:0] limit;

  // The timer restarts from zero on every phase change, so selecting the
  // limit from the registered state is always the phase being timed.
  assign limit = (state == ST_ON) ? ON_LIM : OFF_LIM;

  interval_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .limit (limit),
    .done  (done)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    deq       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending != '0) begin
          deq       = 1'b1;
          start     = 1'b1;
          state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (done) begin
          start     = 1'b1;
          state_nxt = ST_OFF;
        end
      end
      ST_OFF: begin
        if (done) begin
          if (pending != '0) begin
            deq       = 1'b1;
            start     = 1'b1;
            state_nxt = ST_ON;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A full queue still takes an event when a dequeue frees a slot this edge.
  assign accept = event_in && ((pending != PMAX) || deq);
  assign drop   = event_in && !accept;
  assign busy   = (state != ST_IDLE) || (pending != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      led_out  <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      led_out  <= (state_nxt == ST_ON);
      pending  <= pending + PW'(accept) - PW'(deq);
      if (drop)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

endmodule
